// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared widths, transfer types and helpers for the writeback arbiter
package writeback_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  typedef logic [4:0] reg_addr_t;
  typedef struct packed {
    logic            wren;
    reg_addr_t       waddr;
    logic [XLEN-1:0] wdata;
  } register_write_in_type;
  typedef struct packed {
    logic            valid;
    reg_addr_t       waddr;
    logic [XLEN-1:0] wdata;
  } writeback_fast_in_type;
  typedef struct packed {
    logic            valid;
    reg_addr_t       waddr;
    logic [XLEN-1:0] wdata;
  } writeback_slow_in_type;
  typedef struct packed {
    logic                  fast_ready;
    logic                  slow_ready;
    logic                  hazard;
    logic [NREG-1:0]       busy;
    register_write_in_type port;
  } writeback_out_type;
  function automatic logic [NREG-1:0] reg_bit(input reg_addr_t a);
    reg_bit = '0;
    reg_bit[a] = 1'b1;
  endfunction
endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of {waddr, wdata} pairs with wrapping pointers
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [4:0]      push_addr,
  input  logic [XLEN-1:0] push_data,
  output logic [4:0]      head_addr,
  output logic [XLEN-1:0] head_data,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic [4:0] mem_addr [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head_addr = mem_addr[rptr];
  assign head_data = mem_data[rptr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      rptr <= rptr + AW'(pop);
      wptr <= wptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= push_addr;
      mem_data[wptr] <= push_data;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges fast ALU and buffered slow results onto the register-file write port
// with a busy scoreboard; define WB_FORWARD_EN to add write-port forwarding to decode sources.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fast_valid,
  output logic            fast_ready,
  input  logic [4:0]      fast_waddr,
  input  logic [XLEN-1:0] fast_wdata,
  input  logic            slow_valid,
  output logic            slow_ready,
  input  logic [4:0]      slow_waddr,
  input  logic [XLEN-1:0] slow_wdata,
  input  logic            issue_valid,
  input  logic [4:0]      issue_waddr,
  input  logic            rden1,
  input  logic            rden2,
  input  logic            rden3,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  input  logic [4:0]      raddr3,
  output logic            hazard,
  output logic [31:0]     busy,
  output logic            wren,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
`ifdef WB_FORWARD_EN
  ,
  output logic            fwd1,
  output logic            fwd2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  writeback_fast_in_type fast;
  writeback_slow_in_type slow;
  writeback_out_type res;
  logic full, empty, push, pop, throttle, fast_ok, slow_ok, use_fast;
  logic [4:0] head_addr, sel_addr;
  logic [XLEN-1:0] head_data;
  logic [SW-1:0] starve;
  logic [NREG-1:0] busy_q, clr, set, live;
  assign fast = {fast_valid, fast_waddr, fast_wdata};
  assign slow = {slow_valid, slow_waddr, slow_wdata};
  assign throttle = !empty && starve == SW'(STARVE_LIMIT);
  assign fast_ok = rst && !throttle;
  assign slow_ok = rst && !full;
  assign use_fast = fast.valid && fast_ok;
  assign push = slow.valid && slow_ok;
  assign pop = rst && !use_fast && !empty;
  assign sel_addr = use_fast ? fast.waddr : head_addr;
  assign clr = pop ? reg_bit(head_addr) : '0;
  assign set = (issue_valid && issue_waddr != '0) ? reg_bit(issue_waddr) : '0;
`ifdef WB_FORWARD_EN
  // a source whose producer is on the port this cycle is satisfied by forwarding
  assign live = busy_q & ~clr;
`else
  assign live = busy_q;
`endif
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .push_addr(slow.waddr), .push_data(slow.wdata),
    .head_addr(head_addr), .head_data(head_data),
    .full(full), .empty(empty)
  );
  always_comb begin
    res.fast_ready = fast_ok;
    res.slow_ready = slow_ok;
    res.busy = busy_q;
    res.hazard = rst && ((rden1 && live[raddr1]) || (rden2 && live[raddr2]) || (rden3 && busy_q[raddr3]));
    res.port.waddr = sel_addr;
    res.port.wdata = use_fast ? fast.wdata : head_data;
    res.port.wren = (use_fast || pop) && sel_addr != '0;
  end
  assign fast_ready = res.fast_ready;
  assign slow_ready = res.slow_ready;
  assign hazard = res.hazard;
  assign busy = res.busy;
  assign wren = res.port.wren;
  assign waddr = res.port.waddr;
  assign wdata = res.port.wdata;
`ifdef WB_FORWARD_EN
  assign fwd1 = rden1 && res.port.wren && res.port.waddr == raddr1;
  assign fwd2 = rden2 && res.port.wren && res.port.waddr == raddr2;
  assign fwd_data1 = res.port.wdata;
  assign fwd_data2 = res.port.wdata;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
      busy_q <= '0;
    end else begin
      starve <= (empty || pop) ? '0 : starve + 1'b1;
      busy_q <= (busy_q & ~clr) | set;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of port arbitration, starvation throttling and scoreboard
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fast_valid, fast_ready, slow_valid, slow_ready, issue_valid;
  logic [4:0] fast_waddr, slow_waddr, issue_waddr, raddr1, raddr2, raddr3, waddr;
  logic [31:0] fast_wdata, slow_wdata, wdata, busy;
  logic rden1, rden2, rden3, hazard, wren;
`ifdef WB_FORWARD_EN
  logic fwd1, fwd2;
  logic [31:0] fwd_data1, fwd_data2;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic thr;
  always #5 clk = ~clk;
  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .fast_valid(fast_valid), .fast_ready(fast_ready), .fast_waddr(fast_waddr), .fast_wdata(fast_wdata),
    .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_waddr(slow_waddr), .slow_wdata(slow_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .rden1(rden1), .rden2(rden2), .rden3(rden3),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .hazard(hazard), .busy(busy), .wren(wren), .waddr(waddr), .wdata(wdata)
`ifdef WB_FORWARD_EN
    , .fwd1(fwd1), .fwd2(fwd2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  always @(negedge clk) begin
    if (rst && issue_valid && issue_waddr != 5'd0 && busy[issue_waddr]) begin
      n_fail++;
      $error("FAIL illegal_issue: observed busy[%0d]=1 expected 0", issue_waddr);
    end
  end
  initial begin
    {fast_valid, slow_valid, issue_valid, rden1, rden2, rden3} = '0;
    {fast_waddr, slow_waddr, issue_waddr, raddr1, raddr2, raddr3} = '0;
    {fast_wdata, slow_wdata} = '0;
    fast_valid = 1'b1; fast_waddr = 5'd3; fast_wdata = 32'h55;
    slow_valid = 1'b1; slow_waddr = 5'd6; rden1 = 1'b1; raddr1 = 5'd6;
    tick(); tick();
    chk("rst_wren", wren, 0);
    chk("rst_fast_ready", fast_ready, 0);
    chk("rst_slow_ready", slow_ready, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_busy", busy, 0);
    fast_valid = 1'b0; slow_valid = 1'b0; rden1 = 1'b0; rst = 1'b1;
    settle();
    chk("idle_fast_ready", fast_ready, 1);
    chk("idle_slow_ready", slow_ready, 1);
    chk("idle_wren", wren, 0);
    // slow x5 after issue: port in N+1, busy clear at end of N+1
    issue_valid = 1'b1; issue_waddr = 5'd5;
    tick();
    issue_valid = 1'b0;
    slow_valid = 1'b1; slow_waddr = 5'd5; slow_wdata = 32'h1234; rden1 = 1'b1; raddr1 = 5'd5;
    settle();
    chk("t1_busy_set", busy, 32'h20);
    chk("t1_hazard_pre", hazard, 1);
    chk("t1_wren_pre", wren, 0);
    tick();
    slow_valid = 1'b0;
    settle();
    chk("t1_wren", wren, 1);
    chk("t1_waddr", waddr, 5);
    chk("t1_wdata", wdata, 32'h1234);
    chk("t1_busy_n1", busy, 32'h20);
`ifdef WB_FORWARD_EN
    chk("t1_hazard_n1", hazard, 0);
`else
    chk("t1_hazard_n1", hazard, 1);
`endif
    tick();
    chk("t1_busy_n2", busy, 0);
    chk("t1_hazard_n2", hazard, 0);
    chk("t1_wren_n2", wren, 0);
    rden1 = 1'b0;
    // fast and slow together: fast first
    fast_valid = 1'b1; fast_waddr = 5'd3; fast_wdata = 32'hAA;
    slow_valid = 1'b1; slow_waddr = 5'd4; slow_wdata = 32'hBB;
    settle();
    chk("t2_fast_waddr", waddr, 3);
    chk("t2_fast_wdata", wdata, 32'hAA);
    chk("t2_fast_wren", wren, 1);
    tick();
    fast_valid = 1'b0; slow_valid = 1'b0;
    settle();
    chk("t2_slow_waddr", waddr, 4);
    chk("t2_slow_wdata", wdata, 32'hBB);
    chk("t2_slow_wren", wren, 1);
    tick();
    chk("t2_idle_wren", wren, 0);
    // continuous fast traffic with DEPTH+1 slow pushes
    fast_valid = 1'b1; fast_waddr = 5'd1;
    for (int c = 0; c < 27; c++) begin
      fast_wdata = 32'hF00 + c;
      slow_valid = c < 7;
      slow_waddr = 5'(10 + (c < 4 ? c : 4));
      slow_wdata = 32'h100 + (c < 4 ? c : 4);
      settle();
      thr = (c % 5 == 0) && c > 0;
      chk("t3_fast_ready", fast_ready, !thr);
      chk("t3_slow_ready", slow_ready, !(c inside {4, 5, 7, 8, 9, 10}));
      chk("t3_waddr", waddr, thr ? 10 + c / 5 - 1 : 1);
      chk("t3_wdata", wdata, thr ? 32'h100 + c / 5 - 1 : 32'hF00 + c);
      tick();
    end
    fast_valid = 1'b0; slow_valid = 1'b0;
    settle();
    chk("t3_drained_wren", wren, 0);
    // x0 writes are suppressed and never scoreboarded
    fast_valid = 1'b1; fast_waddr = 5'd0; fast_wdata = 32'h5;
    issue_valid = 1'b1; issue_waddr = 5'd0;
    settle();
    chk("t4_x0_wren", wren, 0);
    chk("t4_x0_fast_ready", fast_ready, 1);
    tick();
    fast_valid = 1'b0; issue_valid = 1'b0;
    settle();
    chk("t4_x0_busy", busy, 0);
    // reset with three buffered entries and busy[7]
    issue_valid = 1'b1; issue_waddr = 5'd7;
    tick();
    issue_valid = 1'b0;
    fast_valid = 1'b1; fast_waddr = 5'd2; fast_wdata = 32'h22; slow_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slow_waddr = 5'(20 + i); slow_wdata = 32'(i);
      tick();
    end
    slow_valid = 1'b0; rden3 = 1'b1; raddr3 = 5'd7;
    settle();
    chk("t5_busy7", busy, 32'h80);
    chk("t5_hazard_dest", hazard, 1);
    chk("t5_fast_port", waddr, 2);
    rst = 1'b0;
    settle();
    chk("t5_rst_wren", wren, 0);
    chk("t5_rst_fast_ready", fast_ready, 0);
    chk("t5_rst_slow_ready", slow_ready, 0);
    chk("t5_rst_hazard", hazard, 0);
    tick();
    rst = 1'b1; fast_valid = 1'b0;
    settle();
    chk("t5_busy_clear", busy, 0);
    chk("t5_wren_empty", wren, 0);
    chk("t5_hazard_after", hazard, 0);
    tick();
    chk("t5_wren_empty2", wren, 0);
    rden3 = 1'b0;
`ifdef WB_FORWARD_EN
    issue_valid = 1'b1; issue_waddr = 5'd9;
    tick();
    issue_valid = 1'b0;
    slow_valid = 1'b1; slow_waddr = 5'd9; slow_wdata = 32'h9999; rden2 = 1'b1; raddr2 = 5'd9;
    settle();
    chk("t6_hazard_pre", hazard, 1);
    tick();
    slow_valid = 1'b0;
    settle();
    chk("t6_fwd2", fwd2, 1);
    chk("t6_fwd_data2", fwd_data2, 32'h9999);
    chk("t6_hazard", hazard, 0);
    chk("t6_fwd1", fwd1, 0);
    tick();
    rden2 = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
